avl_bus_nx1_arb: RTL and testbench

N-to-1 Avalon-style bus interconnect that arbitrates MASTER_NUM master ports onto one slave-facing master port, with parametrised address/data width, read/write burst support and a configurable number of outstanding read bursts. Read responses are routed back to the issuing master from an outstanding-tag FIFO. Write bursts hold the grant for the whole burst. It sits between CPU/DMA masters and the memory-side bus, as the successor of the single-beat N-to-1 bus.

---
 rtl/avl_bus_nx1_arb.sv | 246 ++++++++++++++++++++++++
 tb/tb_avl_bus_nx1_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_bus_nx1_arb.sv
// avl_bus_nx1_arb: N-to-1 Avalon-style bus arbiter with read/write burst
// support. Read responses are steered back to the issuing master using an
// outstanding-tag FIFO of {master id, burst length}.
// Write bursts lock the grant to the issuing master until the last beat.
// Optional build macro: AVL_BUS_NX1_RESP_REG_EN adds a 2-entry skid buffer
// on the response path (registered, 1-cycle latency). When the macro is
// undefined the response path is purely combinational.
module avl_bus_nx1_arb #(
    parameter int MASTER_NUM        = 4,
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int BURST_WIDTH       = 4,
    parameter int ARB_METHOD        = 0,
    parameter int OUTSTANDING_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rest,
    input  logic [MASTER_NUM*ADDR_WIDTH-1:0]     s_address,
    input  logic [MASTER_NUM*(DATA_WIDTH/8)-1:0] s_byte_en,
    input  logic [MASTER_NUM-1:0]                s_read,
    input  logic [MASTER_NUM-1:0]                s_write,
    input  logic [MASTER_NUM*DATA_WIDTH-1:0]     s_write_data,
    input  logic [MASTER_NUM-1:0]                s_begin_burst_transfer,
    input  logic [MASTER_NUM*BURST_WIDTH-1:0]    s_burst_count,
    output logic [MASTER_NUM-1:0]                s_request_ready,
    output logic [DATA_WIDTH-1:0]                s_read_data,
    output logic [MASTER_NUM-1:0]                s_read_data_valid,
    input  logic [MASTER_NUM-1:0]                s_resp_ready,
    output logic [ADDR_WIDTH-1:0]                m_address,
    output logic [DATA_WIDTH/8-1:0]              m_byte_en,
    output logic                                 m_read,
    output logic                                 m_write,
    output logic [DATA_WIDTH-1:0]                m_write_data,
    output logic                                 m_begin_burst_transfer,
    output logic [BURST_WIDTH-1:0]               m_burst_count,
    input  logic                                 m_request_ready,
    input  logic [DATA_WIDTH-1:0]                m_read_data,
    input  logic                                 m_read_data_valid,
    output logic                                 m_resp_ready
);
    localparam int IDW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
    localparam int BEW = DATA_WIDTH / 8;
    localparam int PW  = $clog2(OUTSTANDING_DEPTH);
    localparam int CW  = PW + 1;

    // Control state
    logic                   lock_q, lock_d;
    logic [IDW-1:0]         lock_id_q, lock_id_d;
    logic [BURST_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [IDW-1:0]         last_grant_q, last_grant_d;
    logic [BURST_WIDTH-1:0] rcnt_q, rcnt_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;

    // Tag storage (data only, never reset)
    logic [IDW-1:0]         tag_id_q  [OUTSTANDING_DEPTH];
    logic [BURST_WIDTH-1:0] tag_len_q [OUTSTANDING_DEPTH];
    logic [IDW-1:0]         tag_id_d;
    logic [BURST_WIDTH-1:0] tag_len_d;

    logic [MASTER_NUM-1:0]  req;
    logic [IDW-1:0]         sel;
    logic                   rr_found;
    logic                   sel_req, sel_r, sel_w, sel_bb;
    logic [BURST_WIDTH-1:0] sel_bc, sel_len;
    logic                   block, accept, push, pop, empty;
    logic [IDW-1:0]         hid;
    logic [BURST_WIDTH-1:0] hlen, rcnt_inc;
    logic                   up_ready, beat;

    assign req   = s_read | s_write;
    assign block = (count_q == CW'(OUTSTANDING_DEPTH));
    assign empty = (count_q == '0);
    assign hid   = tag_id_q[rd_ptr_q];
    assign hlen  = tag_len_q[rd_ptr_q];

    // Grant selection: locked master during a write burst, otherwise fixed or rotating priority
    always_comb begin
        sel      = '0;
        rr_found = 1'b0;
        if (lock_q) begin
            sel = lock_id_q;
        end else if (ARB_METHOD == 1) begin
            for (int k = 0; k < MASTER_NUM; k++) begin
                if (!rr_found && req[(int'(last_grant_q) + 1 + k) % MASTER_NUM]) begin
                    sel      = IDW'((int'(last_grant_q) + 1 + k) % MASTER_NUM);
                    rr_found = 1'b1;
                end
            end
        end else begin
            for (int k = MASTER_NUM - 1; k >= 0; k--) begin
                if (req[k]) sel = IDW'(k);
            end
        end
    end

    // Command mux and acceptance towards the slave side
    always_comb begin
        sel_req                = req[sel];
        sel_r                  = s_read[sel];
        sel_w                  = s_write[sel];
        sel_bb                 = s_begin_burst_transfer[sel];
        sel_bc                 = s_burst_count[int'(sel)*BURST_WIDTH +: BURST_WIDTH];
        sel_len                = (sel_bc == '0) ? BURST_WIDTH'(1) : sel_bc;
        accept                 = sel_req & m_request_ready & ~block;
        push                   = accept & sel_r;
        m_address              = s_address[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
        m_byte_en              = s_byte_en[int'(sel)*BEW +: BEW];
        m_write_data           = s_write_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
        m_begin_burst_transfer = sel_bb;
        m_burst_count          = sel_bc;
        m_read                 = sel_r & ~block;
        m_write                = sel_w & ~block;
        s_request_ready        = '0;
        s_request_ready[sel]   = accept;
        tag_id_d               = sel;
        tag_len_d              = sel_len;
    end

    // Write-burst lock tracking and round-robin history
    always_comb begin
        lock_d       = lock_q;
        lock_id_d    = lock_id_q;
        wcnt_d       = wcnt_q;
        last_grant_d = accept ? sel : last_grant_q;
        if (accept && sel_w) begin
            if (lock_q) begin
                if (wcnt_q <= BURST_WIDTH'(1)) begin
                    lock_d = 1'b0;
                    wcnt_d = '0;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end else if (sel_bb && (sel_len > BURST_WIDTH'(1))) begin
                lock_d    = 1'b1;
                lock_id_d = sel;
                wcnt_d    = sel_len - 1'b1;
            end
        end
    end

`ifdef AVL_BUS_NX1_RESP_REG_EN
    logic [DATA_WIDTH-1:0] sk_data_q [2];
    logic [IDW-1:0]        sk_id_q   [2];
    logic                  sk_wp_q, sk_wp_d;
    logic                  sk_rp_q, sk_rp_d;
    logic [1:0]            sk_cnt_q, sk_cnt_d;
    logic                  sk_pop;
    logic [IDW-1:0]        sk_hid;

    assign up_ready = ~empty & (sk_cnt_q != 2'd2);

    // Skid buffer: take beats from the slave while a slot is free, drain to the head master
    always_comb begin
        sk_hid            = sk_id_q[sk_rp_q];
        sk_pop            = (sk_cnt_q != 2'd0) & s_resp_ready[sk_hid];
        sk_wp_d           = sk_wp_q ^ beat;
        sk_rp_d           = sk_rp_q ^ sk_pop;
        sk_cnt_d          = sk_cnt_q + {1'b0, beat} - {1'b0, sk_pop};
        s_read_data       = sk_data_q[sk_rp_q];
        s_read_data_valid = '0;
        if (sk_cnt_q != 2'd0) s_read_data_valid[sk_hid] = 1'b1;
    end

    // Skid buffer occupancy and pointers
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            sk_wp_q  <= 1'b0;
            sk_rp_q  <= 1'b0;
            sk_cnt_q <= 2'd0;
        end else begin
            sk_wp_q  <= sk_wp_d;
            sk_rp_q  <= sk_rp_d;
            sk_cnt_q <= sk_cnt_d;
        end
    end

    // Skid buffer payload capture
    always_ff @(posedge clk) begin
        if (beat) begin
            sk_data_q[sk_wp_q] <= m_read_data;
            sk_id_q[sk_wp_q]   <= hid;
        end
    end
`else
    assign up_ready = ~empty & s_resp_ready[hid];

    // Combinational response steering to the head-of-FIFO master
    always_comb begin
        s_read_data       = m_read_data;
        s_read_data_valid = '0;
        if (!empty) s_read_data_valid[hid] = m_read_data_valid;
    end
`endif

    assign m_resp_ready = up_ready;
    assign beat         = m_read_data_valid & up_ready;
    assign rcnt_inc     = rcnt_q + 1'b1;
    assign pop          = beat & (rcnt_inc == hlen);

    // Tag FIFO pointers/occupancy and response beat counter
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rcnt_d   = rcnt_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
        if (beat) rcnt_d = pop ? '0 : rcnt_inc;
    end

    // Control registers
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            wcnt_q       <= '0;
            last_grant_q <= IDW'(MASTER_NUM - 1);
            rcnt_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            wcnt_q       <= wcnt_d;
            last_grant_q <= last_grant_d;
            rcnt_q       <= rcnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Tag payload write on accepted read command
    always_ff @(posedge clk) begin
        if (push) begin
            tag_id_q[wr_ptr_q]  <= tag_id_d;
            tag_len_q[wr_ptr_q] <= tag_len_d;
        end
    end

endmodule

// File: tb/tb_avl_bus_nx1_arb.sv
// Bench for avl_bus_nx1_arb: a fixed-priority instance with a queue-based
// reference model, and a round-robin instance with a rotating-priority model.
module tb_avl_bus_nx1_arb;
    localparam int N = 4, AW = 32, DW = 32, BEW = 4, BW = 4, DEPTH = 4;

    logic clk = 1'b0;
    logic rest = 1'b0;
    always #5 clk = ~clk;

    // Fixed-priority instance signals
    logic [N*AW-1:0]  s_address;
    logic [N*BEW-1:0] s_byte_en;
    logic [N-1:0]     s_read, s_write, s_bb, s_resp_ready;
    logic [N*DW-1:0]  s_write_data;
    logic [N*BW-1:0]  s_burst_count;
    logic [N-1:0]     s_request_ready, s_read_data_valid;
    logic [DW-1:0]    s_read_data;
    logic [AW-1:0]    m_address;
    logic [BEW-1:0]   m_byte_en;
    logic             m_read, m_write, m_bb, m_request_ready, m_read_data_valid, m_resp_ready;
    logic [DW-1:0]    m_write_data, m_read_data;
    logic [BW-1:0]    m_burst_count;

    // Round-robin instance signals
    logic [N*AW-1:0]  r_s_address;
    logic [N*BEW-1:0] r_s_byte_en;
    logic [N-1:0]     r_s_read, r_s_write, r_s_bb, r_s_resp_ready;
    logic [N*DW-1:0]  r_s_write_data;
    logic [N*BW-1:0]  r_s_burst_count;
    logic [N-1:0]     r_s_request_ready, r_s_read_data_valid;
    logic [DW-1:0]    r_s_read_data;
    logic [AW-1:0]    r_m_address;
    logic [BEW-1:0]   r_m_byte_en;
    logic             r_m_read, r_m_write, r_m_bb, r_m_request_ready, r_m_read_data_valid, r_m_resp_ready;
    logic [DW-1:0]    r_m_write_data, r_m_read_data;
    logic [BW-1:0]    r_m_burst_count;

    avl_bus_nx1_arb #(.MASTER_NUM(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW),
                      .ARB_METHOD(0), .OUTSTANDING_DEPTH(DEPTH)) dut (
        .clk(clk), .rest(rest),
        .s_address(s_address), .s_byte_en(s_byte_en), .s_read(s_read), .s_write(s_write),
        .s_write_data(s_write_data), .s_begin_burst_transfer(s_bb), .s_burst_count(s_burst_count),
        .s_request_ready(s_request_ready), .s_read_data(s_read_data),
        .s_read_data_valid(s_read_data_valid), .s_resp_ready(s_resp_ready),
        .m_address(m_address), .m_byte_en(m_byte_en), .m_read(m_read), .m_write(m_write),
        .m_write_data(m_write_data), .m_begin_burst_transfer(m_bb), .m_burst_count(m_burst_count),
        .m_request_ready(m_request_ready), .m_read_data(m_read_data),
        .m_read_data_valid(m_read_data_valid), .m_resp_ready(m_resp_ready));

    avl_bus_nx1_arb #(.MASTER_NUM(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW),
                      .ARB_METHOD(1), .OUTSTANDING_DEPTH(DEPTH)) dut_rr (
        .clk(clk), .rest(rest),
        .s_address(r_s_address), .s_byte_en(r_s_byte_en), .s_read(r_s_read), .s_write(r_s_write),
        .s_write_data(r_s_write_data), .s_begin_burst_transfer(r_s_bb), .s_burst_count(r_s_burst_count),
        .s_request_ready(r_s_request_ready), .s_read_data(r_s_read_data),
        .s_read_data_valid(r_s_read_data_valid), .s_resp_ready(r_s_resp_ready),
        .m_address(r_m_address), .m_byte_en(r_m_byte_en), .m_read(r_m_read), .m_write(r_m_write),
        .m_write_data(r_m_write_data), .m_begin_burst_transfer(r_m_bb), .m_burst_count(r_m_burst_count),
        .m_request_ready(r_m_request_ready), .m_read_data(r_m_read_data),
        .m_read_data_valid(r_m_read_data_valid), .m_resp_ready(r_m_resp_ready));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model state: outstanding read bursts as {master, beats left}
    typedef struct { int id; int rem; } tag_t;
    tag_t mq[$];
    bit   mlock;
    int   mlock_id;
    int   mwrem;
    int   rlast;

    // Fixed-priority model: check every cycle, then advance model state
    always @(negedge clk) begin : model_p
        logic [N-1:0]  req;
        logic [BW-1:0] bc;
        int   sel, hid, len;
        bit   full, acc, beat;
        tag_t t;
        if (!rest) begin
            mq.delete();
            mlock = 0; mlock_id = 0; mwrem = 0;
        end else begin
            req = s_read | s_write;
            if (mlock) sel = mlock_id;
            else begin
                sel = 0;
                for (int i = N - 1; i >= 0; i--) if (req[i]) sel = i;
            end
            full = (mq.size() >= DEPTH);
            acc  = req[sel] && m_request_ready && !full;
            bc   = s_burst_count[sel*BW +: BW];
            len  = (bc == 0) ? 1 : int'(bc);
            check("req_ready", 64'(s_request_ready), acc ? (64'd1 << sel) : 64'd0);
            check("m_read", 64'(m_read), 64'(s_read[sel] && !full));
            check("m_write", 64'(m_write), 64'(s_write[sel] && !full));
            if (req != 0) begin
                check("m_address", 64'(m_address), 64'(s_address[sel*AW +: AW]));
                check("m_wdata", 64'(m_write_data), 64'(s_write_data[sel*DW +: DW]));
                check("m_byte_en", 64'(m_byte_en), 64'(s_byte_en[sel*BEW +: BEW]));
                check("m_burst", 64'(m_burst_count), 64'(bc));
            end
            beat = 0;
            if (mq.size() == 0) begin
                check("idle_valid", 64'(s_read_data_valid), 64'd0);
                check("idle_resp_ready", 64'(m_resp_ready), 64'd0);
            end else begin
                hid = mq[0].id;
                check("rd_valid", 64'(s_read_data_valid), m_read_data_valid ? (64'd1 << hid) : 64'd0);
                check("m_resp_ready", 64'(m_resp_ready), 64'(s_resp_ready[hid]));
                if (m_read_data_valid) check("rd_data", 64'(s_read_data), 64'(m_read_data));
                beat = m_read_data_valid && s_resp_ready[hid];
            end
            if (beat) begin
                mq[0].rem = mq[0].rem - 1;
                if (mq[0].rem == 0) void'(mq.pop_front());
            end
            if (acc && s_read[sel]) begin
                t.id = sel; t.rem = len;
                mq.push_back(t);
            end
            if (acc && s_write[sel]) begin
                if (mlock) begin
                    mwrem = mwrem - 1;
                    if (mwrem == 0) mlock = 0;
                end else if (s_bb[sel] && len > 1) begin
                    mlock = 1; mlock_id = sel; mwrem = len - 1;
                end
            end
        end
    end

    // Round-robin model: search starts just after the last accepted master
    always @(negedge clk) begin : rr_model_p
        logic [N-1:0] rreq;
        int  rs;
        bit  racc;
        if (!rest) rlast = N - 1;
        else begin
            rreq = r_s_read | r_s_write;
            rs = -1;
            for (int k = 1; k <= N; k++) if (rs < 0 && rreq[(rlast + k) % N]) rs = (rlast + k) % N;
            racc = (rs >= 0) && r_m_request_ready;
            check("rr_req_ready", 64'(r_s_request_ready), racc ? (64'd1 << rs) : 64'd0);
            if (racc) begin
                check("rr_m_address", 64'(r_m_address), 64'(r_s_address[rs*AW +: AW]));
                rlast = rs;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        s_read = '0; s_write = '0; s_bb = '0; s_burst_count = '0;
        s_resp_ready = '1; m_request_ready = 1'b1; m_read_data_valid = 1'b0;
        r_s_read = '0; r_s_write = '0; r_s_bb = '0; r_s_burst_count = '0;
        r_s_resp_ready = '1; r_m_request_ready = 1'b1; r_m_read_data_valid = 1'b0;
    endtask

    task automatic set_cmd(input int i, input bit rd, input bit wr, input bit bb, input int bc);
        s_read[i] = rd; s_write[i] = wr; s_bb[i] = bb;
        s_burst_count[i*BW +: BW] = BW'(bc);
        s_address[i*AW +: AW] = 32'hA000_0000 + 32'(i);
        s_write_data[i*DW +: DW] = $urandom;
    endtask

    logic [N-1:0] rr_exp [5];
    int rnd;
    int guard;

    initial begin
        s_address = '0; s_byte_en = '1; s_write_data = '0; m_read_data = '0;
        r_s_address = '0; r_s_byte_en = '1; r_s_write_data = '0; r_m_read_data = '0;
        idle_all();
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

        // Reset state
        #2;
        check("rst_req_ready", 64'(s_request_ready), 64'd0);
        check("rst_valid", 64'(s_read_data_valid), 64'd0);
        check("rst_resp_ready", 64'(m_resp_ready), 64'd0);
        check("rst_m_read", 64'(m_read), 64'd0);
        check("rst_m_write", 64'(m_write), 64'd0);
        step(); step();
        rest = 1'b1;

        // Round robin, all masters requesting: 0,1,2,3,0
        step();
        for (int i = 0; i < N; i++) begin
            r_s_address[i*AW +: AW] = 32'hB000_0000 + 32'(i);
            r_s_burst_count[i*BW +: BW] = 4'd1;
        end
        r_s_write = '1; r_s_bb = '1;
        #1 check("rr_order0", 64'(r_s_request_ready), 64'(rr_exp[0]));
        for (int k = 1; k < 5; k++) begin
            step();
            #1 check($sformatf("rr_order%0d", k), 64'(r_s_request_ready), 64'(rr_exp[k]));
        end
        step(); idle_all();

        // Fixed priority: masters 0 and 2 single reads in the same cycle
        set_cmd(0, 1, 0, 0, 1); set_cmd(2, 1, 0, 0, 1);
        #1 check("fp_grant0", 64'(s_request_ready), 64'b0001);
        check("fp_addr0", 64'(m_address), 64'hA000_0000);
        step(); s_read[0] = 1'b0;
        #1 check("fp_grant2", 64'(s_request_ready), 64'b0100);
        check("fp_addr2", 64'(m_address), 64'hA000_0002);
        step(); s_read = '0; m_read_data_valid = 1'b1; m_read_data = 32'hD000_0000;
        #1 check("fp_resp0", 64'(s_read_data_valid), 64'b0001);
        check("fp_data0", 64'(s_read_data), 64'hD000_0000);
        step(); m_read_data = 32'hD000_0002;
        #1 check("fp_resp2", 64'(s_read_data_valid), 64'b0100);
        step();
        #1 check("fp_empty_valid", 64'(s_read_data_valid), 64'd0);
        check("fp_empty_ready", 64'(m_resp_ready), 64'd0);
        step(); idle_all();

        // Write burst L=4 from master 1 holds the grant against master 0
        set_cmd(1, 0, 1, 1, 4);
        #1 check("wb_beat0", 64'(s_request_ready), 64'b0010);
        check("wb_mwrite0", 64'(m_write), 64'd1);
        for (int k = 1; k < 4; k++) begin
            step(); s_bb[1] = 1'b0; set_cmd(0, 1, 0, 0, 1);
            #1 check($sformatf("wb_beat%0d", k), 64'(s_request_ready), 64'b0010);
        end
        step(); s_write[1] = 1'b0;
        #1 check("wb_after", 64'(s_request_ready), 64'b0001);
        step(); s_read = '0; m_read_data_valid = 1'b1;
        #1 check("wb_resp0", 64'(s_read_data_valid), 64'b0001);
        step(); idle_all();

        // Master 3 read burst L=8 then master 0 single read
        set_cmd(3, 1, 0, 0, 8);
        #1 check("rb_grant3", 64'(s_request_ready), 64'b1000);
        step(); s_read[3] = 1'b0; set_cmd(0, 1, 0, 0, 1);
        #1 check("rb_grant0", 64'(s_request_ready), 64'b0001);
        step(); s_read = '0; m_read_data_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            m_read_data = 32'hC300_0000 + 32'(k);
            #1 check($sformatf("rb_beat3_%0d", k), 64'(s_read_data_valid), 64'b1000);
            step();
        end
        #1 check("rb_beat0", 64'(s_read_data_valid), 64'b0001);
        step();
        #1 check("rb_empty", 64'(m_resp_ready), 64'd0);
        step(); idle_all();

        // Five single reads with no responses: fifth held until a pop
        set_cmd(0, 1, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            #1 check($sformatf("os_acc%0d", k), 64'(s_request_ready), 64'b0001);
            step();
        end
        #1 check("os_block_ready", 64'(s_request_ready), 64'd0);
        check("os_block_mread", 64'(m_read), 64'd0);
        step(); m_read_data_valid = 1'b1;
        #1 check("os_pop_same_cycle", 64'(s_request_ready), 64'd0);
        step(); m_read_data_valid = 1'b0;
        #1 check("os_acc_after_pop", 64'(s_request_ready), 64'b0001);
        step(); s_read = '0; m_read_data_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 check($sformatf("os_drain%0d", k), 64'(s_read_data_valid), 64'b0001);
            step();
        end
        #1 check("os_empty", 64'(m_resp_ready), 64'd0);
        step(); idle_all();

        // Backpressure from master 2 and burst_count=0 single beat
        set_cmd(2, 1, 0, 0, 0);
        #1 check("bp_grant2", 64'(s_request_ready), 64'b0100);
        step(); s_read = '0; s_resp_ready = 4'b1011; m_read_data_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("bp_hold_ready%0d", k), 64'(m_resp_ready), 64'd0);
            check($sformatf("bp_hold_valid%0d", k), 64'(s_read_data_valid), 64'b0100);
            step();
        end
        s_resp_ready = '1;
        #1 check("bp_release", 64'(m_resp_ready), 64'd1);
        step();
        #1 check("bp_single_beat", 64'(m_resp_ready), 64'd0);
        check("bp_single_valid", 64'(s_read_data_valid), 64'd0);
        step(); idle_all();

        // Reset in the middle of a read burst and a write burst
        set_cmd(0, 1, 0, 0, 3);
        step(); s_read = '0; set_cmd(1, 0, 1, 1, 4);
        step(); s_write = '0; rest = 1'b0; m_read_data_valid = 1'b1;
        #1 check("mr_resp_ready", 64'(m_resp_ready), 64'd0);
        check("mr_valid", 64'(s_read_data_valid), 64'd0);
        step(); rest = 1'b1; m_read_data_valid = 1'b0; set_cmd(2, 1, 0, 0, 1);
        #1 check("mr_unlocked", 64'(s_request_ready), 64'b0100);
        step(); s_read = '0; m_read_data_valid = 1'b1;
        #1 check("mr_resp2", 64'(s_read_data_valid), 64'b0100);
        step(); idle_all();

        // Randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                rnd = $urandom_range(0, 9);
                s_read[i] = 1'b0; s_write[i] = 1'b0;
                if (mlock && mlock_id == i) s_write[i] = ($urandom_range(0, 4) != 0);
                else if (rnd < 4) s_read[i] = 1'b1;
                else if (rnd < 6) s_write[i] = 1'b1;
                s_bb[i] = 1'($urandom_range(0, 1));
                s_burst_count[i*BW +: BW] = BW'($urandom_range(0, 4));
                s_address[i*AW +: AW] = $urandom;
                s_write_data[i*DW +: DW] = $urandom;
                s_byte_en[i*BEW +: BEW] = BEW'($urandom);
                s_resp_ready[i] = ($urandom_range(0, 3) != 0);
                r_s_write[i] = 1'($urandom_range(0, 1));
                r_s_bb[i] = 1'($urandom_range(0, 1));
                r_s_burst_count[i*BW +: BW] = BW'($urandom_range(0, 1));
                r_s_address[i*AW +: AW] = $urandom;
            end
            m_request_ready = ($urandom_range(0, 3) != 0);
            m_read_data_valid = ($urandom_range(0, 4) < 3);
            m_read_data = $urandom;
            r_m_request_ready = ($urandom_range(0, 9) < 7);
        end

        // Drain outstanding responses, bounded
        step(); idle_all(); m_read_data_valid = 1'b1;
        guard = 0;
        while (mq.size() != 0 && guard < 300) begin
            step(); guard++;
        end
        step();
        #1 check("drain_resp_ready", 64'(m_resp_ready), 64'd0);
        check("drain_valid", 64'(s_read_data_valid), 64'd0);
        step(); idle_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
